// File: rtl/phi1_mul_stream.sv
// Streaming multiply of a ternary polynomial by (x - 1) mod (x^N - 1), two coefficients per beat,
// results reduced mod 2^Q_BITS. Output order c_1..c_{N-1}, then c_0 on a final single-lane beat.
module phi1_mul_stream #(
  parameter int N      = 701,
  parameter int Q_BITS = 13,
  parameter int IDX_W  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_coef,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*Q_BITS-1:0]   out_coef,
  output logic                  out_lane1_vld,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int LAST_K_INT = (N - 1) / 2;
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(LAST_K_INT);

  generate
    if ((N < 3) || ((N % 2) == 0)) begin : g_bad_n
      $error("phi1_mul_stream: N must be odd and >= 3");
    end
    if ((1 << IDX_W) < ((N + 1) / 2)) begin : g_bad_idx
      $error("phi1_mul_stream: IDX_W too narrow for N");
    end
    if (Q_BITS < 4) begin : g_bad_q
      $error("phi1_mul_stream: Q_BITS must be >= 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_STREAM,
    S_TAIL,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0]       v0_code;
  logic [1:0]       prev_even;
  logic [1:0]       prev_odd;
  logic [IDX_W-1:0] in_cnt;

  logic accept_in, accept_out, out_free, load_stream, load_tail;
  logic [Q_BITS-1:0] stream_l0, stream_l1, tail_l0;

  // Code 10 is not a legal trit and is treated as zero.
  function automatic logic signed [2:0] trit(input logic [1:0] code);
    case (code)
      2'b01:   return 3'sd1;
      2'b11:   return -3'sd1;
      default: return 3'sd0;
    endcase
  endfunction

  function automatic logic [Q_BITS-1:0] modq(input logic signed [2:0] d);
    return {{(Q_BITS-3){d[2]}}, d};
  endfunction

  assign out_free   = !out_valid || out_ready;
  assign accept_in  = in_valid && in_ready;
  assign accept_out = out_valid && out_ready;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  // Beat j = k-1 needs v_{2j}, v_{2j+1} (held pair) and v_{2j+2} (lane0 of the incoming beat).
  assign stream_l0 = modq(trit(prev_even) - trit(prev_odd));
  assign stream_l1 = modq(trit(prev_odd) - trit(in_coef[1:0]));
  assign tail_l0   = modq(trit(prev_even) - trit(v0_code));

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    load_stream = 1'b0;
    load_tail   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FIRST;
      end
      S_FIRST: begin
        in_ready = out_free;
        if (in_valid && out_free) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        in_ready    = out_free;
        load_stream = in_valid && out_free;
        if (load_stream && (in_cnt == LAST_K)) state_nxt = S_TAIL;
      end
      S_TAIL: begin
        load_tail = out_free;
        if (out_free) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (accept_out) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // On the last input beat prev_even ends up holding v_{N-1}, which the tail beat needs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      v0_code       <= 2'b00;
      prev_even     <= 2'b00;
      prev_odd      <= 2'b00;
      in_cnt        <= '0;
      out_valid     <= 1'b0;
      out_coef      <= '0;
      out_lane1_vld <= 1'b0;
      out_idx       <= '0;
      out_last      <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && start) begin
        in_cnt <= '0;
      end
      if (accept_in) begin
        in_cnt    <= in_cnt + 1'b1;
        prev_even <= in_coef[1:0];
        prev_odd  <= in_coef[3:2];
        if (state == S_FIRST) v0_code <= in_coef[1:0];
      end
      if (load_stream) begin
        out_valid     <= 1'b1;
        out_coef      <= {stream_l1, stream_l0};
        out_lane1_vld <= 1'b1;
        out_idx       <= in_cnt - 1'b1;
        out_last      <= 1'b0;
      end else if (load_tail) begin
        out_valid     <= 1'b1;
        out_coef      <= {{Q_BITS{1'b0}}, tail_l0};
        out_lane1_vld <= 1'b0;
        out_idx       <= LAST_K;
        out_last      <= 1'b1;
      end else if (accept_out) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
